btb_predictor: RTL and testbench

Fetch-stage branch target buffer and 2-bit direction predictor; the reader side of the execute stage's branch-resolution interface. Each cycle it looks up the fetch PC and produces the predicted-taken flag and next PC consumed by fetch. The flag travels down the pipeline to the execute stage as `predictedTaken`. The execute stage returns `update_btb`, `jump_addr` and `modify_pc`, which this block uses to train its table. It also keeps branch/mispredict counters for benchmarking.

---
 rtl/btb_predictor.sv | 142 ++++++++++++++
 tb/tb_btb_predictor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor
//   Fetch-stage branch target buffer with a 2-bit saturating direction
//   counter per entry. It is direct-mapped and indexed by pc[INDEX_BITS+1:2].
//   Lookup is purely combinational from fetch_pc and the registered table.
//   The table is trained by the execute stage's branch-resolution stream.
//   It also keeps saturating branch and mispredict counters.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   fetch_pc          PC looked up this cycle
//   predicted_taken   hit && counter predicts taken
//   predicted_pc      predicted target, or fetch_pc + 4
//   upd_valid         a resolved control-flow instruction is presented this cycle
//   upd_pc            PC of the resolved instruction
//   upd_target        resolved target
//   upd_taken         actual outcome
//   upd_jump          unconditional jump (JAL/JALR)
//   upd_mispredict    execute redirected the PC
//   clear_stats       synchronous clear of both counters (wins over increment)
//   branch_count      number of resolved control-flow instructions
//   mispredict_count  number of resolved mispredictions
//
// Handshake: the update port is valid-only. The block always accepts
// (there is no ready). Every cycle with upd_valid=1 at a rising edge is one
// transaction. The other upd_* inputs are don't-care when upd_valid=0.

module btb_predictor #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_jump,
    input  logic        upd_mispredict,
    input  logic        clear_stats,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    // Low through reset and during the first edge after release, so that an
    // update coinciding with the release edge is dropped.
    logic live_q;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic                  upd_en;
    logic [1:0]            ctr_next;

    // The low address bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Lookup on the fetch side
    always_comb begin
        f_idx           = fetch_pc[INDEX_BITS+1:2];
        f_tag           = fetch_pc[31:INDEX_BITS+2];
        f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predicted_taken = f_hit && ctr_q[f_idx][1];
        predicted_pc    = predicted_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    end

    // Update decode
    always_comb begin
        u_idx  = upd_pc[INDEX_BITS+1:2];
        u_tag  = upd_pc[31:INDEX_BITS+2];
        u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        upd_en = upd_valid && live_q;
        ctr_next = ctr_q[u_idx];
        if (upd_jump) begin
            ctr_next = 2'b11;
        end else if (upd_taken) begin
            if (ctr_q[u_idx] != 2'b11) ctr_next = ctr_q[u_idx] + 2'd1;
        end else begin
            if (ctr_q[u_idx] != 2'b00) ctr_next = ctr_q[u_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_next;
                // A not-taken conditional keeps the learned target.
                if (upd_jump || upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                // Allocate on a taken miss; this evicts any alias.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= upd_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (clear_stats) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd_en) begin
            if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
            if (upd_mispredict && (mispredict_count != 32'hFFFF_FFFF))
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc = 32'h0000_0100;
    logic        predicted_taken;
    logic [31:0] predicted_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_jump = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad = 0;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .predicted_taken(predicted_taken), .predicted_pc(predicted_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_jump(upd_jump),
        .upd_mispredict(upd_mispredict), .clear_stats(clear_stats),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: a table of 16 lines holding the line's tag and
    // target, plus a direction counter (0..3) kept as a plain int.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_br;
    longint      m_mp;

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i] = 0;
            m_tgt[i] = 0;
            m_ctr[i] = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[line_of(pc)] && (m_tag[line_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        return model_hit(pc) && (m_ctr[line_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_pc(input logic [31:0] pc);
        return model_taken(pc) ? m_tgt[line_of(pc)] : pc + 32'd4;
    endfunction

    initial model_clear();
    always @(negedge rst_n) model_clear();

    // The bench never presents an update on the reset-release edge, so the
    // model applies every update seen while out of reset.
    always @(posedge clk) begin
        if (rst_n) begin
            if (clear_stats) begin
                m_br = 0;
                m_mp = 0;
            end else if (upd_valid) begin
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (upd_mispredict && m_mp < 64'hFFFF_FFFF) m_mp++;
            end
            if (upd_valid) begin
                automatic int l = line_of(upd_pc);
                if (model_hit(upd_pc)) begin
                    if (upd_jump) begin
                        m_ctr[l] = 3;
                        m_tgt[l] = upd_target;
                    end else if (upd_taken) begin
                        m_ctr[l] = (m_ctr[l] + 1 > 3) ? 3 : m_ctr[l] + 1;
                        m_tgt[l] = upd_target;
                    end else begin
                        m_ctr[l] = (m_ctr[l] - 1 < 0) ? 0 : m_ctr[l] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[l] = 1;
                    m_tag[l] = tag_of(upd_pc);
                    m_tgt[l] = upd_target;
                    m_ctr[l] = upd_jump ? 3 : 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: the outputs are meaningful on every cycle.
    always @(negedge clk) begin
        check("cyc_taken", {31'b0, predicted_taken}, {31'b0, model_taken(fetch_pc)});
        check("cyc_pc", predicted_pc, model_pc(fetch_pc));
        check("cyc_branch_count", branch_count, m_br[31:0]);
        check("cyc_mispredict_count", mispredict_count, m_mp[31:0]);
    end

    // Driver tasks. Each update occupies one cycle; inputs change just
    // after the falling edge.
    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic jp, input logic mp);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_target = tgt;
        upd_taken = tk;
        upd_jump = jp;
        upd_mispredict = mp;
        @(negedge clk);
        #1;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        upd_jump = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_pc);
        fetch_pc = pc;
        #1;
        check({name, "_taken"}, {31'b0, predicted_taken}, {31'b0, exp_tk});
        check({name, "_pc"}, predicted_pc, exp_pc);
    endtask

    initial begin
        // Reset state
        #2;
        look("rst_hold", 32'h0000_0100, 1'b0, 32'h0000_0104);
        check("rst_hold_bc", branch_count, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        look("post_rst", 32'h0000_0100, 1'b0, 32'h0000_0104);
        check("post_rst_bc", branch_count, 32'd0);
        check("post_rst_mc", mispredict_count, 32'd0);

        // Taken allocate -> ctr 10, then not-taken -> ctr 01
        do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
        look("alloc", 32'h0000_0100, 1'b1, 32'h0000_0200);
        do_upd(32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        look("weaken", 32'h0000_0100, 1'b0, 32'h0000_0104);

        // Saturation up, then down to 00 while staying valid
        for (int i = 0; i < 4; i++) do_upd(32'h100, 32'h280, 1'b1, 1'b0, 1'b0);
        look("sat_up", 32'h0000_0100, 1'b1, 32'h0000_0280);
        do_upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
        look("one_down", 32'h0000_0100, 1'b1, 32'h0000_0280);
        for (int i = 0; i < 4; i++) do_upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
        look("sat_down", 32'h0000_0100, 1'b0, 32'h0000_0104);
        // From 00 a taken update reaches 01 only; a fresh allocation would give 10.
        do_upd(32'h100, 32'h2A0, 1'b1, 1'b0, 1'b0);
        look("still_valid", 32'h0000_0100, 1'b0, 32'h0000_0104);
        do_upd(32'h100, 32'h2A0, 1'b1, 1'b0, 1'b0);
        look("back_taken", 32'h0000_0100, 1'b1, 32'h0000_02A0);

        // Not-taken miss never allocates
        do_upd(32'h180, 32'h400, 1'b0, 1'b0, 1'b0);
        look("nt_miss", 32'h0000_0180, 1'b0, 32'h0000_0184);

        // Aliasing: 0x140 shares index 0 with 0x100
        do_upd(32'h140, 32'h340, 1'b1, 1'b0, 1'b0);
        look("alias_new", 32'h0000_0140, 1'b1, 32'h0000_0340);
        look("alias_old", 32'h0000_0100, 1'b0, 32'h0000_0104);

        // A jump allocates at 11: one not-taken still predicts taken
        do_upd(32'h208, 32'h1000, 1'b1, 1'b1, 1'b0);
        do_upd(32'h208, 32'h1000, 1'b0, 1'b0, 1'b0);
        look("jump_strong", 32'h0000_0208, 1'b1, 32'h0000_1000);

        // Same-cycle lookup and update: there is no bypass
        fetch_pc = 32'h0000_0300;
        upd_valid = 1'b1;
        upd_pc = 32'h300;
        upd_target = 32'h500;
        upd_taken = 1'b1;
        upd_jump = 1'b0;
        #1;
        check("same_cyc_pc", predicted_pc, 32'h0000_0304);
        @(negedge clk);
        #1;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        check("next_cyc_pc", predicted_pc, 32'h0000_0500);

        // Wraparound of fetch_pc + 4
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Statistics
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        check("clr_bc", branch_count, 32'd0);
        for (int i = 0; i < 10; i++)
            do_upd(32'h600 + 32'(i * 4), 32'h700, 1'(i % 2), 1'b0, 1'(i < 3));
        check("bc10", branch_count, 32'd10);
        check("mc3", mispredict_count, 32'd3);
        clear_stats = 1'b1;
        do_upd(32'h600, 32'h700, 1'b1, 1'b0, 1'b1);
        clear_stats = 1'b0;
        check("clr_upd_bc", branch_count, 32'd0);
        check("clr_upd_mc", mispredict_count, 32'd0);
        do_upd(32'h604, 32'h700, 1'b1, 1'b0, 1'b1);
        check("after_clr_bc", branch_count, 32'd1);

        // Asynchronous reset mid-run
        do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        fetch_pc = 32'h0000_0100;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_taken", {31'b0, predicted_taken}, 32'd0);
        check("mid_rst_pc", predicted_pc, 32'h0000_0104);
        check("mid_rst_bc", branch_count, 32'd0);
        check("mid_rst_mc", mispredict_count, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        look("mid_rst_clear", 32'h0000_0500 - 32'h200, 1'b0, 32'h0000_0304);
        do_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        look("relearn", 32'h0000_0100, 1'b1, 32'h0000_0200);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
